// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared fetch-stage types: FSM states and BTB entry layout
package if_fetch_unit_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } lc3b_fetch_state;

  typedef logic [15:0] lc3b_word;

  // 2-bit saturating branch counter; bit 1 is the taken prediction
  typedef logic [1:0] lc3b_btb_counter;

  // Widest tag needed is for the smallest table (2 entries): pc[15:2]
  localparam int BTB_TAG_W = 14;
  typedef logic [BTB_TAG_W-1:0] lc3b_btb_tag;

  typedef struct packed {
    logic            valid;
    lc3b_btb_tag     tag;
    lc3b_word        target;
    lc3b_btb_counter counter;
  } lc3b_btb_entry;

  localparam lc3b_word PC_STEP = 16'd2;

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer with 2-bit counters
module fetch_btb
  import if_fetch_unit_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word lookup_pc,
  output logic     lookup_hit,
  output logic     lookup_prediction,
  output lc3b_word lookup_target,
  input  logic     update_en,
  input  lc3b_word update_pc,
  input  lc3b_word update_target,
  input  logic     update_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  lc3b_btb_entry mem_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  lc3b_btb_tag      lookup_tag;
  lc3b_btb_tag      update_tag;
  lc3b_btb_entry    lookup_entry;
  lc3b_btb_entry    update_entry;
  lc3b_btb_entry    entry_d;
  logic             write_en;
  logic             update_hit;
  logic             unused_lsb;

  // Instructions are word aligned, so bit 0 never takes part in index or tag
  assign unused_lsb = lookup_pc[0] ^ update_pc[0];

  assign lookup_idx = lookup_pc[IDX_W:1];
  assign update_idx = update_pc[IDX_W:1];
  assign lookup_tag = lc3b_btb_tag'(lookup_pc >> (IDX_W + 1));
  assign update_tag = lc3b_btb_tag'(update_pc >> (IDX_W + 1));

  // Lookup reads the registered table, so a same-cycle update is not yet visible
  always_comb begin
    lookup_entry      = mem_q[lookup_idx];
    lookup_hit        = lookup_entry.valid && (lookup_entry.tag == lookup_tag);
    lookup_prediction = lookup_hit && lookup_entry.counter[1];
    lookup_target     = lookup_hit ? lookup_entry.target : 16'h0000;
  end

  // Resolved-branch update: train on hit, allocate on taken miss, ignore not-taken miss
  always_comb begin
    update_entry = mem_q[update_idx];
    update_hit   = update_entry.valid && (update_entry.tag == update_tag);
    entry_d      = update_entry;
    write_en     = 1'b0;
    if (update_en) begin
      if (update_hit) begin
        write_en = 1'b1;
        if (update_taken) begin
          entry_d.target = update_target;
          if (update_entry.counter != 2'b11) begin
            entry_d.counter = update_entry.counter + 2'd1;
          end
        end else if (update_entry.counter != 2'b00) begin
          entry_d.counter = update_entry.counter - 2'd1;
        end
      end else if (update_taken) begin
        write_en = 1'b1;
        entry_d  = '{valid: 1'b1, tag: update_tag, target: update_target, counter: 2'b10};
      end
    end
  end

  // Table storage; reset only invalidates entries
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (write_en) begin
      mem_q[update_idx] <= entry_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - LC-3b fetch front end feeding IF/ID; BTB built only when IF_FETCH_BTB_EN is defined
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_id_ready,
  input  logic        flush,
  input  logic [15:0] flush_target,
  output logic        icache_read,
  output logic [15:0] icache_address,
  input  logic [15:0] icache_rdata,
  input  logic        icache_resp,
  output logic        fetch_valid,
  output logic        i_cache_stall,
  output logic [15:0] fetch_ir,
  output logic [15:0] fetch_pc,
  output logic        fetch_prediction,
  output logic        fetch_predictor,
  output logic [15:0] fetch_btb_target,
  output logic [15:0] fetch_flush_pc,
  input  logic        btb_update,
  input  logic [15:0] btb_update_pc,
  input  logic [15:0] btb_update_target,
  input  logic        btb_update_taken
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        redirect_pc_q, redirect_pc_d;
  lc3b_word        hold_ir_q, hold_ir_d;
  logic            hold_pred_q, hold_pred_d;
  logic            hold_hit_q, hold_hit_d;
  lc3b_word        hold_target_q, hold_target_d;
  lc3b_word        hold_next_pc_q, hold_next_pc_d;

  logic     live_hit;
  logic     live_pred;
  lc3b_word live_target;
  lc3b_word live_next_pc;
  lc3b_word pc_plus2;

  logic     valid_c;
  lc3b_word ir_c;
  logic     pred_c;
  logic     hit_c;
  lc3b_word target_c;

`ifdef IF_FETCH_BTB_EN
  fetch_btb #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk              (clk),
    .reset            (reset),
    .lookup_pc        (pc_q),
    .lookup_hit       (live_hit),
    .lookup_prediction(live_pred),
    .lookup_target    (live_target),
    .update_en        (btb_update),
    .update_pc        (btb_update_pc),
    .update_target    (btb_update_target),
    .update_taken     (btb_update_taken)
  );
`else
  logic unused_btb_port;

  assign live_hit        = 1'b0;
  assign live_pred       = 1'b0;
  assign live_target     = 16'h0000;
  assign unused_btb_port = ^{btb_update, btb_update_pc, btb_update_target, btb_update_taken,
                             7'(BTB_ENTRIES)};
`endif

  // Wraps mod 2^16, so FFFE steps to 0000
  assign pc_plus2     = pc_q + PC_STEP;
  assign live_next_pc = live_pred ? live_target : pc_plus2;

  // Fetch sequencing: next PC, hold capture and the instruction presented to IF/ID
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    redirect_pc_d  = redirect_pc_q;
    hold_ir_d      = hold_ir_q;
    hold_pred_d    = hold_pred_q;
    hold_hit_d     = hold_hit_q;
    hold_target_d  = hold_target_q;
    hold_next_pc_d = hold_next_pc_q;
    valid_c        = 1'b0;
    ir_c           = 16'h0000;
    pred_c         = 1'b0;
    hit_c          = 1'b0;
    target_c       = 16'h0000;
    case (state_q)
      FETCH: begin
        if (flush) begin
          if (icache_resp) begin
            pc_d = flush_target;
          end else begin
            redirect_pc_d = flush_target;
            state_d       = DRAIN;
          end
        end else if (icache_resp) begin
          valid_c  = 1'b1;
          ir_c     = icache_rdata;
          pred_c   = live_pred;
          hit_c    = live_hit;
          target_c = live_target;
          if (if_id_ready) begin
            pc_d = live_next_pc;
          end else begin
            hold_ir_d      = icache_rdata;
            hold_pred_d    = live_pred;
            hold_hit_d     = live_hit;
            hold_target_d  = live_target;
            hold_next_pc_d = live_next_pc;
            state_d        = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d    = flush_target;
          state_d = FETCH;
        end else begin
          valid_c  = 1'b1;
          ir_c     = hold_ir_q;
          pred_c   = hold_pred_q;
          hit_c    = hold_hit_q;
          target_c = hold_target_q;
          if (if_id_ready) begin
            pc_d    = hold_next_pc_q;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (icache_resp) begin
          pc_d    = flush ? flush_target : redirect_pc_q;
          state_d = FETCH;
        end else if (flush) begin
          redirect_pc_d = flush_target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Fetch state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= 16'h0000;
      redirect_pc_q  <= 16'h0000;
      hold_ir_q      <= 16'h0000;
      hold_pred_q    <= 1'b0;
      hold_hit_q     <= 1'b0;
      hold_target_q  <= 16'h0000;
      hold_next_pc_q <= 16'h0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redirect_pc_q  <= redirect_pc_d;
      hold_ir_q      <= hold_ir_d;
      hold_pred_q    <= hold_pred_d;
      hold_hit_q     <= hold_hit_d;
      hold_target_q  <= hold_target_d;
      hold_next_pc_q <= hold_next_pc_d;
    end
  end

  // HOLD is the only state without an outstanding read; pc is held while a read is open
  assign icache_read      = (state_q != HOLD);
  assign icache_address   = pc_q;
  assign fetch_valid      = valid_c;
  assign i_cache_stall    = ~valid_c;
  assign fetch_ir         = ir_c;
  assign fetch_pc         = valid_c ? pc_plus2 : 16'h0000;
  assign fetch_flush_pc   = fetch_pc;
  assign fetch_prediction = pred_c;
  assign fetch_predictor  = hit_c;
  assign fetch_btb_target = target_c;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit against a transaction-level model
module tb_if_fetch_unit;

  localparam int BTB_ENTRIES = 16;
  localparam bit BTB_ON =
`ifdef IF_FETCH_BTB_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_ready;
  logic        flush;
  logic [15:0] flush_target;
  logic        icache_read;
  logic [15:0] icache_address;
  logic [15:0] icache_rdata;
  logic        icache_resp;
  logic        fetch_valid;
  logic        i_cache_stall;
  logic [15:0] fetch_ir;
  logic [15:0] fetch_pc;
  logic        fetch_prediction;
  logic        fetch_predictor;
  logic [15:0] fetch_btb_target;
  logic [15:0] fetch_flush_pc;
  logic        btb_update;
  logic [15:0] btb_update_pc;
  logic [15:0] btb_update_target;
  logic        btb_update_taken;

  if_fetch_unit #(.BTB_ENTRIES(BTB_ENTRIES)) dut (
    .clk(clk), .reset(reset), .if_id_ready(if_id_ready), .flush(flush),
    .flush_target(flush_target), .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp), .fetch_valid(fetch_valid),
    .i_cache_stall(i_cache_stall), .fetch_ir(fetch_ir), .fetch_pc(fetch_pc),
    .fetch_prediction(fetch_prediction), .fetch_predictor(fetch_predictor),
    .fetch_btb_target(fetch_btb_target), .fetch_flush_pc(fetch_flush_pc),
    .btb_update(btb_update), .btb_update_pc(btb_update_pc),
    .btb_update_target(btb_update_target), .btb_update_taken(btb_update_taken)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: architectural PC of the next request and a BTB kept as plain arrays keyed by word index
  logic [15:0] m_pc;
  bit          mb_v   [BTB_ENTRIES];
  logic [15:0] mb_pc  [BTB_ENTRIES];
  logic [15:0] mb_tgt [BTB_ENTRIES];
  int          mb_ctr [BTB_ENTRIES];

  bit          rand_upd = 1'b0;
  bit          u_en = 1'b0;
  logic [15:0] u_pc, u_tgt;
  bit          u_tk;

  task automatic check_val(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_target();
    return 16'(($urandom % 128) * 2);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      mb_v[i] = 1'b0;
      mb_ctr[i] = 0;
    end
  endfunction

  function automatic void model_update(logic [15:0] p, logic [15:0] t, bit taken);
    int i = int'((p >> 1) % BTB_ENTRIES);
    if (!BTB_ON) return;
    if (mb_v[i] && ((mb_pc[i] >> 1) == (p >> 1))) begin
      if (taken) begin
        if (mb_ctr[i] < 3) mb_ctr[i]++;
        mb_tgt[i] = t;
      end else if (mb_ctr[i] > 0) begin
        mb_ctr[i]--;
      end
    end else if (taken) begin
      mb_v[i] = 1'b1;
      mb_pc[i] = p;
      mb_tgt[i] = t;
      mb_ctr[i] = 2;
    end
  endfunction

  task automatic m_lookup(input logic [15:0] p, output bit hit, output bit pred,
                          output logic [15:0] tgt);
    int i = int'((p >> 1) % BTB_ENTRIES);
    hit  = BTB_ON && mb_v[i] && ((mb_pc[i] >> 1) == (p >> 1));
    pred = hit && (mb_ctr[i] >= 2);
    tgt  = hit ? mb_tgt[i] : 16'h0000;
  endtask

  // Drive one cycle's inputs and wait to the sampling point
  task automatic drive(bit resp, logic [15:0] rd, bit rdy, bit fl, logic [15:0] ft);
    icache_resp  = resp;
    icache_rdata = rd;
    if_id_ready  = rdy;
    flush        = fl;
    flush_target = ft;
    if (rand_upd) begin
      u_en  = (($urandom % 4) == 0);
      u_pc  = (($urandom % 2) == 0) ? m_pc : rand_target();
      u_tgt = rand_target();
      u_tk  = 1'($urandom % 2);
    end
    btb_update        = u_en;
    btb_update_pc     = u_pc;
    btb_update_target = u_tgt;
    btb_update_taken  = u_tk;
    @(negedge clk);
  endtask

  // Clock edge; BTB update becomes visible to the model only after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (u_en) model_update(u_pc, u_tgt, u_tk);
    u_en        = 1'b0;
    btb_update  = 1'b0;
    icache_resp = 1'b0;
    flush       = 1'b0;
    if_id_ready = 1'b0;
  endtask

  task automatic check_fields(logic [15:0] ir, bit hit, bit pred, logic [15:0] tgt);
    check_val("fetch_ir", fetch_ir, ir);
    check_val("fetch_pc", fetch_pc, m_pc + 16'd2);
    check_val("fetch_flush_pc", fetch_flush_pc, m_pc + 16'd2);
    check_val("fetch_predictor", 16'(fetch_predictor), 16'(hit));
    check_val("fetch_prediction", 16'(fetch_prediction), 16'(pred));
    check_val("fetch_btb_target", fetch_btb_target, tgt);
  endtask

  // One instruction: response after lat cycles, then stall cycles waiting for IF/ID
  task automatic run_fetch(int lat, int stall, logic [15:0] ir);
    bit          hit, pred;
    logic [15:0] tgt, exp_next;
    hit = 1'b0; pred = 1'b0; tgt = 16'h0000;
    for (int c = 0; c < lat; c++) begin
      bit last = (c == lat - 1);
      if (last) m_lookup(m_pc, hit, pred, tgt);
      drive(last, last ? ir : 16'($urandom), last ? (stall == 0) : 1'($urandom % 2), 1'b0, 16'h0);
      check_val("icache_read", 16'(icache_read), 16'd1);
      check_val("icache_address", icache_address, m_pc);
      check_val("fetch_valid", 16'(fetch_valid), 16'(last));
      check_val("i_cache_stall", 16'(i_cache_stall), 16'(!last));
      if (last) check_fields(ir, hit, pred, tgt);
      step();
    end
    exp_next = pred ? tgt : m_pc + 16'd2;
    for (int s = 1; s <= stall; s++) begin
      drive(1'b0, 16'($urandom), s == stall, 1'b0, 16'h0);
      check_val("hold_icache_read", 16'(icache_read), 16'd0);
      check_val("hold_fetch_valid", 16'(fetch_valid), 16'd1);
      check_fields(ir, hit, pred, tgt);
      step();
    end
    m_pc = exp_next;
  endtask

  // Outstanding read redirected by one or more flushes; newest target wins, word discarded
  task automatic run_flush_miss(int lat, int f1, logic [15:0] t1, bit more);
    logic [15:0] final_tgt = t1;
    for (int c = 0; c < lat; c++) begin
      bit          fl = (c == f1) || (more && c > f1 && ($urandom % 3) == 0);
      logic [15:0] ft = (c == f1) ? t1 : rand_target();
      if (fl) final_tgt = ft;
      drive(c == lat - 1, 16'($urandom), 1'($urandom % 2), fl, ft);
      check_val("drain_icache_read", 16'(icache_read), 16'd1);
      check_val("drain_icache_address", icache_address, m_pc);
      check_val("drain_fetch_valid", 16'(fetch_valid), 16'd0);
      step();
    end
    m_pc = final_tgt;
  endtask

  // Word captured into hold, then flushed away while held
  task automatic run_hold_flush(int k, logic [15:0] ft, bit rdy);
    bit          hit, pred;
    logic [15:0] tgt;
    logic [15:0] ir = 16'($urandom);
    m_lookup(m_pc, hit, pred, tgt);
    drive(1'b1, ir, 1'b0, 1'b0, 16'h0);
    check_val("hf_resp_valid", 16'(fetch_valid), 16'd1);
    check_fields(ir, hit, pred, tgt);
    step();
    for (int i = 0; i < k; i++) begin
      drive(1'b0, 16'($urandom), 1'b0, 1'b0, 16'h0);
      check_val("hf_hold_valid", 16'(fetch_valid), 16'd1);
      check_fields(ir, hit, pred, tgt);
      step();
    end
    drive(1'b0, 16'($urandom), rdy, 1'b1, ft);
    check_val("hf_flush_valid", 16'(fetch_valid), 16'd0);
    check_val("hf_flush_read", 16'(icache_read), 16'd0);
    step();
    m_pc = ft;
  endtask

  task automatic explicit_update(logic [15:0] p, logic [15:0] t, bit taken);
    u_en = 1'b1; u_pc = p; u_tgt = t; u_tk = taken;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check_val("upd_icache_address", icache_address, m_pc);
    check_val("upd_fetch_valid", 16'(fetch_valid), 16'd0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 16'($urandom), 1'b0, 1'b0, 16'h0);
    step();
    reset = 1'b0;
    m_pc  = 16'h0000;
    model_clear();
  endtask

  initial begin
    reset = 1'b1; if_id_ready = 1'b0; flush = 1'b0; flush_target = 16'h0;
    icache_rdata = 16'h0; icache_resp = 1'b0; btb_update = 1'b0;
    btb_update_pc = 16'h0; btb_update_target = 16'h0; btb_update_taken = 1'b0;
    u_pc = 16'h0; u_tgt = 16'h0; u_tk = 1'b0;
    m_pc = 16'h0000;
    model_clear();
    step();
    step();
    reset = 1'b0;

    // Reset state
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check_val("rst_icache_read", 16'(icache_read), 16'd1);
    check_val("rst_icache_address", icache_address, 16'h0000);
    check_val("rst_i_cache_stall", 16'(i_cache_stall), 16'd1);
    check_val("rst_fetch_valid", 16'(fetch_valid), 16'd0);
    check_val("rst_fetch_ir", fetch_ir, 16'h0000);
    check_val("rst_fetch_pc", fetch_pc, 16'h0000);
    check_val("rst_fetch_btb_target", fetch_btb_target, 16'h0000);
    check_val("rst_fetch_prediction", 16'(fetch_prediction), 16'd0);
    step();

    // Back-to-back single-cycle hits
    for (int i = 0; i < 3; i++) run_fetch(1, 0, 16'($urandom));
    // Held word across three not-ready cycles
    run_fetch(1, 4, 16'h1234);
    run_fetch(1, 0, 16'($urandom));
    // Flush coincident with response, then long miss redirected mid-flight
    run_flush_miss(1, 0, 16'h0010, 1'b0);
    run_flush_miss(4, 1, 16'h0100, 1'b0);
    run_fetch(1, 0, 16'($urandom));
    // BTB training, prediction and de-training
    explicit_update(16'h0020, 16'h0080, 1'b1);
    run_flush_miss(1, 0, 16'h0020, 1'b0);
    run_fetch(1, 0, 16'($urandom));
    run_fetch(1, 0, 16'($urandom));
    explicit_update(16'h0020, 16'h0000, 1'b0);
    explicit_update(16'h0020, 16'h0000, 1'b0);
    run_flush_miss(1, 0, 16'h0020, 1'b0);
    run_fetch(1, 0, 16'($urandom));
    // PC wraparound
    run_flush_miss(1, 0, 16'hFFFE, 1'b0);
    run_fetch(1, 0, 16'($urandom));
    run_fetch(1, 0, 16'($urandom));
    // Flush wins over ready while holding
    run_hold_flush(2, 16'h0040, 1'b1);
    run_fetch(2, 0, 16'($urandom));

    // Randomized traffic with random BTB updates
    rand_upd = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int kind = int'($urandom_range(0, 3));
      if (n == 75) do_reset();
      case (kind)
        0, 1: run_fetch(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 16'($urandom));
        2: begin
          int lat = int'($urandom_range(1, 4));
          run_flush_miss(lat, int'($urandom_range(0, lat - 1)), rand_target(), 1'b1);
        end
        default: run_hold_flush(int'($urandom_range(0, 2)), rand_target(), 1'($urandom % 2));
      endcase
    end
    rand_upd = 1'b0;
    run_fetch(1, 0, 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
